swervolf_wb_initiator: RTL and testbench
========================================

SWERVOLF_WB_INITIATOR -- requirements
Module: swervolf_wb_initiator

Interface
REQ-001 SHALL have parameter AW, default 32, Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, max bus cycles awaiting ack; 0 disables timeout.
REQ-003 SHALL have port i_clk  input  1  clock; all state on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_cmd_valid  input  1  command request.
REQ-006 SHALL have port o_cmd_ready  output  1  command accepted when high with i_cmd_valid.
REQ-007 SHALL have ports i_cmd_we (input, 1), i_cmd_adr (input, AW), i_cmd_dat (input, 32) and i_cmd_sel (input, 4): write flag, address, write data and byte lanes.
REQ-008 SHALL have ports o_rsp_valid (output, 1), i_rsp_ready (input, 1), o_rsp_dat (output, 32) and o_rsp_err (output, 1): response handshake, read data, error flag.
REQ-009 SHALL have ports o_wb_adr (output, AW), o_wb_dat (output, 32), o_wb_sel (output, 4), o_wb_we (output, 1), o_wb_cyc (output, 1) and o_wb_stb (output, 1): Wishbone classic initiator outputs.
REQ-010 SHALL have ports i_wb_rdt (input, 32), i_wb_ack (input, 1) and i_wb_err (input, 1): responder read data, ack, error (tied low for responders without err).

Function
REQ-011 SHALL implement FSM with states IDLE, BUS and RESP; all outputs registered.
REQ-012 o_cmd_ready SHALL be high only in IDLE; handshake (valid&ready) at edge E0 latches we/adr/dat/sel into o_wb_* and enters BUS.
REQ-013 In BUS, o_wb_cyc and o_wb_stb SHALL both be high; o_wb_adr/dat/sel/we SHALL stay stable until exit.
REQ-014 Ack sampled high at edge Ek SHALL deassert cyc/stb after Ek (exactly one cycle later), enter RESP, o_rsp_err=0, o_rsp_dat=i_wb_rdt for reads or 0 for writes.
REQ-015 Against a responder acking one cycle after cyc, cyc/stb SHALL be high exactly 2 cycles and o_rsp_valid SHALL rise 2 cycles after E0; no second ack is provoked.
REQ-016 i_wb_err sampled high in BUS SHALL end the cycle as REQ-014 with o_rsp_err=1, o_rsp_dat=0.
REQ-017 Timeout counter SHALL clear on BUS entry, increment each BUS cycle without ack/err; on reaching TIMEOUT_CYCLES, cycle ends with o_rsp_err=1, o_rsp_dat=0.
REQ-018 Ack and err in the same cycle: err wins; ack or err in the cycle timeout is reached: ack/err wins over timeout.
REQ-019 In RESP, o_rsp_valid SHALL be high and o_rsp_dat/o_rsp_err stable until i_rsp_ready; then return to IDLE the next cycle (no back-to-back accept in the handshake cycle).
REQ-020 i_wb_ack/i_wb_err outside BUS SHALL be ignored with no state change.
REQ-021 Timeout counter SHALL be 8 bits minimum, sized $clog2(TIMEOUT_CYCLES+1), saturating, never wrapping.

Reset
REQ-022 i_rst SHALL force IDLE; o_wb_cyc=0, o_wb_stb=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_rsp_valid=0, o_rsp_dat=0, o_rsp_err=0, counter=0; o_cmd_ready=1 after first post-reset edge.
REQ-023 Reset in BUS or RESP SHALL drop cyc/stb and o_rsp_valid the following cycle and discard the pending response.

Structure
REQ-024 FSM state enum and default TIMEOUT_CYCLES SHALL live in shared package swervolf_wb_pkg.
REQ-025 No sub-module; timeout counter and FSM SHALL be inline.

Verification
REQ-026 Write adr=0x0C dat=0x8000_0000 sel=0xF to swervolf_syscon -> cyc high 2 cycles, rsp_valid, err=0; readback adr=0x0C returns 0x8000_0000.
REQ-027 Read adr=0x3C from syscon (clk_freq_hz=50_000_000) -> o_rsp_dat=0x02FA_F080, err=0, rsp 2 cycles after accept.
REQ-028 TIMEOUT_CYCLES=4, responder never acks -> cyc drops after 4 BUS cycles, o_rsp_err=1, o_rsp_dat=0.
REQ-029 i_rsp_ready held low 10 cycles -> o_rsp_valid/dat stable 10 cycles, o_cmd_ready=0 throughout; second command accepted only after IDLE return.
REQ-030 i_rst asserted one cycle into BUS -> cyc/stb low next cycle, no o_rsp_valid; stray ack afterwards ignored.
REQ-031 i_wb_ack and i_wb_err high together -> o_rsp_err=1, o_rsp_dat=0.

Source files
------------

// File: rtl/swervolf_wb_pkg.sv
// Shared definitions for the SweRVolf Wishbone initiator: FSM states,
// default ack timeout and the timeout counter sizing rule.
package swervolf_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_RESP
  } wb_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Counter is never narrower than 8 bits so small timeouts still saturate cleanly.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/swervolf_wb_initiator.sv
// Single-outstanding Wishbone classic initiator: accepts one command, runs
// one bus cycle with ack/err/timeout termination, holds the response.
import swervolf_wb_pkg::*;

module swervolf_wb_initiator #(
  parameter int AW             = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cmd_valid,
  output logic          o_cmd_ready,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_adr,
  input  logic [31:0]   i_cmd_dat,
  input  logic [3:0]    i_cmd_sel,
  output logic          o_rsp_valid,
  input  logic          i_rsp_ready,
  output logic [31:0]   o_rsp_dat,
  output logic          o_rsp_err,
  output logic [AW-1:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic          i_wb_err
);

  localparam int            CW       = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic          TO_EN    = (TIMEOUT_CYCLES != 0);

  wb_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic          r_cmd_ready;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_dat;
  logic          r_rsp_err;
  logic [AW-1:0] r_wb_adr;
  logic [31:0]   r_wb_dat;
  logic [3:0]    r_wb_sel;
  logic          r_wb_we;
  logic          r_wb_cyc;

  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;
  logic          w_done;

  // Saturating increment; the limit is judged on the value the counter is about to reach.
  assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_timeout  = TO_EN && (w_cnt_next >= TO_LIMIT);
  assign w_done     = i_wb_err || i_wb_ack || w_timeout;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_wb_adr    <= '0;
      r_wb_dat    <= '0;
      r_wb_sel    <= '0;
      r_wb_we     <= 1'b0;
      r_wb_cyc    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            r_wb_adr    <= i_cmd_adr;
            r_wb_dat    <= i_cmd_dat;
            r_wb_sel    <= i_cmd_sel;
            r_wb_we     <= i_cmd_we;
            r_wb_cyc    <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_BUS;
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_BUS: begin
          if (w_done) begin
            r_wb_cyc    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
            // err beats ack; a timeout only counts when neither arrived
            if (i_wb_ack && !i_wb_err) begin
              r_rsp_err <= 1'b0;
              r_rsp_dat <= r_wb_we ? 32'd0 : i_wb_rdt;
            end else begin
              r_rsp_err <= 1'b1;
              r_rsp_dat <= 32'd0;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cmd_ready = r_cmd_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_dat   = r_rsp_dat;
  assign o_rsp_err   = r_rsp_err;
  assign o_wb_adr    = r_wb_adr;
  assign o_wb_dat    = r_wb_dat;
  assign o_wb_sel    = r_wb_sel;
  assign o_wb_we     = r_wb_we;
  assign o_wb_cyc    = r_wb_cyc;
  assign o_wb_stb    = r_wb_cyc;

endmodule

// File: tb/tb_swervolf_wb_initiator.sv
// Bench for swervolf_wb_initiator against a small syscon-like responder with
// programmable ack latency and error injection.
module tb_swervolf_wb_initiator;

  localparam int          TMO     = 4;
  localparam logic [31:0] CLK_REG = 32'h02FA_F080;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_we;
  logic [31:0] i_cmd_adr;
  logic [31:0] i_cmd_dat;
  logic [3:0]  i_cmd_sel;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_dat;
  logic        o_rsp_err;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic [31:0] i_wb_rdt;
  logic        i_wb_ack;
  logic        i_wb_err;

  int n_checks = 0;
  int n_errors = 0;

  // responder configuration and state
  int        cfg_lat   = 0;
  bit        cfg_err   = 1'b0;
  bit        stray_ack = 1'b0;
  logic      r_ack     = 1'b0;
  logic      r_err     = 1'b0;
  int        r_wcnt    = 0;
  bit [31:0] rmem [16];
  bit [31:0] mmem [16];

  always #5 i_clk = ~i_clk;

  swervolf_wb_initiator #(.AW(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_we(i_cmd_we), .i_cmd_adr(i_cmd_adr), .i_cmd_dat(i_cmd_dat), .i_cmd_sel(i_cmd_sel),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
    .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_rdt(i_wb_rdt), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  assign i_wb_ack = r_ack | stray_ack;
  assign i_wb_err = r_err;
  assign i_wb_rdt = (o_wb_adr[7:0] == 8'h3C) ? CLK_REG : rmem[o_wb_adr[5:2]];

  // Responder: acks (or acks+errs) cfg_lat cycles after it first sees the strobe.
  always @(posedge i_clk) begin
    if (o_wb_cyc && o_wb_stb && !r_ack) begin
      if (r_wcnt == cfg_lat) begin
        r_ack <= 1'b1;
        r_err <= cfg_err;
      end
      r_wcnt <= r_wcnt + 1;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_wcnt <= 0;
    end
    if (o_wb_cyc && o_wb_stb && i_wb_ack && !i_wb_err && o_wb_we && o_wb_adr[7:0] != 8'h3C)
      for (int b = 0; b < 4; b++)
        if (o_wb_sel[b]) rmem[o_wb_adr[5:2]][8*b +: 8] <= o_wb_dat[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] model_read(input bit [7:0] adr);
    return (adr == 8'h3C) ? CLK_REG : mmem[adr[5:2]];
  endfunction

  // One command end to end; expectations come from latency/timeout arithmetic.
  task automatic do_cmd(input string tag, input bit we, input bit [7:0] adr,
                        input bit [31:0] dat, input bit [3:0] sel,
                        input int lat, input bit emode, input int hold, input bit pend);
    int        exp_len;
    bit        exp_err;
    bit [31:0] exp_dat;
    int        k;
    int        bad;
    bit [31:0] held;
    if (lat + 2 <= TMO) begin
      exp_len = lat + 2;
      exp_err = emode;
      exp_dat = (emode || we) ? 32'd0 : model_read(adr);
    end else begin
      exp_len = TMO;
      exp_err = 1'b1;
      exp_dat = 32'd0;
    end
    if (!exp_err && we && adr != 8'h3C)
      for (int b = 0; b < 4; b++)
        if (sel[b]) mmem[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
    cfg_lat = lat;
    cfg_err = emode;

    @(negedge i_clk);
    k = 0;
    while (!o_cmd_ready && k < 20) begin
      @(negedge i_clk);
      k++;
    end
    chk({tag, ".ready"}, 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_we    = we;
    i_cmd_adr   = 32'(adr);
    i_cmd_dat   = dat;
    i_cmd_sel   = sel;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    chk({tag, ".cyc"}, {30'd0, o_wb_cyc, o_wb_stb}, 32'd3);

    k   = 0;
    bad = 0;
    while (!o_rsp_valid && k < 40) begin
      @(posedge i_clk);
      #1;
      k++;
      if (!o_rsp_valid && (!o_wb_cyc || !o_wb_stb || o_wb_adr != 32'(adr) || o_wb_we != we ||
                           o_wb_dat != dat || o_wb_sel != sel)) bad++;
      if (o_cmd_ready) bad++;
    end
    chk({tag, ".len"}, 32'(k), 32'(exp_len));
    chk({tag, ".bus"}, 32'(bad), 32'd0);
    chk({tag, ".drop"}, {30'd0, o_wb_cyc, o_wb_stb}, 32'd0);
    chk({tag, ".dat"}, o_rsp_dat, exp_dat);
    chk({tag, ".err"}, 32'(o_rsp_err), 32'(exp_err));

    if (hold > 0) begin
      held = o_rsp_dat;
      bad  = 0;
      i_cmd_valid = pend;
      repeat (hold) begin
        @(posedge i_clk);
        #1;
        if (!o_rsp_valid || o_rsp_dat != held || o_rsp_err != exp_err || o_cmd_ready || o_wb_cyc) bad++;
      end
      i_cmd_valid = 1'b0;
      chk({tag, ".hold"}, 32'(bad), 32'd0);
    end

    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    chk({tag, ".idle"}, {30'd0, o_rsp_valid, o_cmd_ready}, 32'd1);
  endtask

  initial begin
    int        lat;
    bit        we;
    bit [7:0]  adr;
    i_rst       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_we    = 1'b0;
    i_cmd_adr   = '0;
    i_cmd_dat   = '0;
    i_cmd_sel   = '0;
    i_rsp_ready = 1'b0;

    // reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst.adr", o_wb_adr, 32'd0);
    chk("rst.wdat", o_wb_dat, 32'd0);
    chk("rst.rdat", o_rsp_dat, 32'd0);
    chk("rst.flags", {24'd0, o_wb_sel, o_wb_we, o_wb_cyc, o_wb_stb, o_rsp_valid},
        32'd0);
    chk("rst.misc", {30'd0, o_rsp_err, o_cmd_ready}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rst.ready", 32'(o_cmd_ready), 32'd1);

    // directed transactions
    do_cmd("wr0c", 1'b1, 8'h0C, 32'h8000_0000, 4'hF, 0, 1'b0, 0, 1'b0);
    do_cmd("rd0c", 1'b0, 8'h0C, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
    do_cmd("rd3c", 1'b0, 8'h3C, 32'h0, 4'hF, 0, 1'b0, 0, 1'b0);
    do_cmd("tmo", 1'b0, 8'h10, 32'h0, 4'hF, 1000, 1'b0, 0, 1'b0);
    do_cmd("tmoedge", 1'b0, 8'h0C, 32'h0, 4'hF, 2, 1'b0, 0, 1'b0);
    do_cmd("tmolate", 1'b1, 8'h14, 32'h1234_5678, 4'hF, 3, 1'b0, 0, 1'b0);
    do_cmd("ackerr", 1'b0, 8'h0C, 32'h0, 4'hF, 0, 1'b1, 0, 1'b0);
    do_cmd("hold", 1'b0, 8'h0C, 32'h0, 4'hF, 1, 1'b0, 10, 1'b1);
    do_cmd("wrlane", 1'b1, 8'h20, 32'hA5A5_5A5A, 4'b0101, 0, 1'b0, 0, 1'b0);
    do_cmd("rdlane", 1'b0, 8'h20, 32'h0, 4'hF, 1, 1'b0, 0, 1'b0);

    // reset one cycle into BUS, then a stray ack
    cfg_lat = 1000;
    cfg_err = 1'b0;
    @(negedge i_clk);
    i_cmd_valid = 1'b1;
    i_cmd_we    = 1'b0;
    i_cmd_adr   = 32'h0C;
    @(posedge i_clk);
    #1;
    i_cmd_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rstbus.incyc", 32'(o_wb_cyc), 32'd1);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rstbus.drop", {29'd0, o_wb_cyc, o_wb_stb, o_rsp_valid}, 32'd0);
    @(negedge i_clk);
    i_rst     = 1'b0;
    stray_ack = 1'b1;
    @(posedge i_clk);
    #1;
    stray_ack = 1'b0;
    chk("stray.ign", {29'd0, o_wb_cyc, o_rsp_valid, o_cmd_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    chk("stray.idle", {29'd0, o_wb_cyc, o_rsp_valid, o_cmd_ready}, 32'd1);

    // randomized traffic
    for (int i = 0; i < 30; i++) begin
      we  = 1'($urandom_range(0, 1));
      adr = {2'b00, 4'($urandom_range(0, 15)), 2'b00};
      lat = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 4));
      do_cmd($sformatf("rnd%0d", i), we, adr, $urandom, 4'($urandom_range(1, 15)),
             lat, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
